map_fwd_ctrl: RTL

Forward-recursion and LLR read-out controller for the MAP decoder. It consumes the backward-metric (beta) SRAM after the backward controller has filled it, reading stored beta words in ascending trellis order. For each stage it sequences the alpha add and compare datapath and presents one LLR per stage to the downstream consumer over a valid/ready handshake. It sits between the beta SRAM read port, the ACS datapath enables and the LLR output stage.

---
 rtl/map_pkg.sv | 27 ++
 rtl/map_stage_addr.sv | 32 +++
 rtl/map_fwd_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared MAP decoder definitions: controller state encoding, default geometry
// and the stage address helper used by both the forward and backward controllers.
package map_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_ADD  = 3'd2,
    ST_CMP  = 3'd3,
    ST_OUT  = 3'd4,
    ST_DONE = 3'd5
  } map_state_e;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_STEP       = 8;
  localparam int DEF_BASE_ADDR  = 8;
  localparam int DEF_N_STAGES   = 8;
  localparam int DEF_ALPHA_BASE = 128;

  // Full-width result; callers truncate to their address width (modulo wrap).
  function automatic logic [31:0] stage_addr(input logic [31:0] base,
                                             input logic [3:0]  idx,
                                             input logic [31:0] step);
    return base + 32'(idx) * step;
  endfunction

endpackage

// File: rtl/map_stage_addr.sv
// Registered stride-address generator: loads BASE + idx*STEP (mod 2^ADDR_W)
// when i_load is high and holds the value otherwise.
module map_stage_addr
  import map_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STEP   = DEF_STEP,
  parameter int BASE   = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [3:0]        i_idx,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;

  assign w_addr = ADDR_W'(stage_addr(32'(BASE), i_idx, 32'(STEP)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= w_addr;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/map_fwd_ctrl.sv
// Forward-recursion / LLR read-out controller for the MAP decoder.
// Optional alpha store write port enabled by defining MAP_FWD_ALPHA_STORE_EN.
module map_fwd_ctrl
  import map_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STEP       = DEF_STEP,
  parameter int BASE_ADDR  = DEF_BASE_ADDR,
  parameter int N_STAGES   = DEF_N_STAGES,
  parameter int ALPHA_BASE = DEF_ALPHA_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              llr_ready,
  output logic [ADDR_W-1:0] bd_addr,
  output logic              rd_en,
  output logic              add_en,
  output logic              cmp_en,
  output logic              llr_valid,
  output logic [3:0]        stage_idx,
  output logic              busy,
  output logic              done
`ifdef MAP_FWD_ALPHA_STORE_EN
  ,
  output logic [ADDR_W-1:0] af_addr,
  output logic              af_we
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(N_STAGES - 1);

  if (N_STAGES < 1 || N_STAGES > 15 ||
      BASE_ADDR < 0 || BASE_ADDR >= (1 << ADDR_W) ||
      ALPHA_BASE < 0 || ALPHA_BASE >= (1 << ADDR_W)) begin : g_param_err
    $error("map_fwd_ctrl: parameter out of range");
  end

  map_state_e r_state;
  map_state_e w_state_next;
  logic [3:0] r_stage_idx;
  logic [3:0] w_idx_next;
  logic       r_rd_en;
  logic       r_add_en;
  logic       r_cmp_en;
  logic       r_llr_valid;
  logic       r_done;
  logic       r_busy;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_stage_idx;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RD;
          w_idx_next   = '0;
        end
      end
      ST_RD:  w_state_next = ST_ADD;
      ST_ADD: w_state_next = ST_CMP;
      ST_CMP: w_state_next = ST_OUT;
      ST_OUT: begin
        // llr_valid is always high in OUT, so llr_ready alone marks the transfer.
        if (llr_ready) begin
          if (r_stage_idx == LAST_IDX) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RD;
            w_idx_next   = r_stage_idx + 4'd1;
          end
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet aligned with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_stage_idx <= '0;
      r_rd_en     <= 1'b0;
      r_add_en    <= 1'b0;
      r_cmp_en    <= 1'b0;
      r_llr_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stage_idx <= w_idx_next;
      r_rd_en     <= (w_state_next == ST_RD);
      r_add_en    <= (w_state_next == ST_ADD);
      r_cmp_en    <= (w_state_next == ST_CMP);
      r_llr_valid <= (w_state_next == ST_OUT);
      r_done      <= (w_state_next == ST_DONE);
      r_busy      <= (w_state_next != ST_IDLE);
    end
  end

  map_stage_addr #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP),
    .BASE   (BASE_ADDR)
  ) u_beta_addr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_state_next == ST_RD),
    .i_idx  (w_idx_next),
    .o_addr (bd_addr)
  );

`ifdef MAP_FWD_ALPHA_STORE_EN
  logic r_af_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_af_we <= 1'b0;
    end else begin
      r_af_we <= (w_state_next == ST_CMP);
    end
  end

  map_stage_addr #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP),
    .BASE   (ALPHA_BASE)
  ) u_alpha_addr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_state_next == ST_CMP),
    .i_idx  (r_stage_idx),
    .o_addr (af_addr)
  );

  assign af_we = r_af_we;
`endif

  assign rd_en     = r_rd_en;
  assign add_en    = r_add_en;
  assign cmp_en    = r_cmp_en;
  assign llr_valid = r_llr_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign stage_idx = r_stage_idx;

endmodule
